alu_mult_seq: RTL and testbench

- Multi-cycle multiply sequencer that reuses the single shared ALU, through its ALUOP/porta/portb/out interface, as its only adder.
- Computes the low 32 bits of a 32x32 product, signed or unsigned, by shift-add iteration.
- Sits beside the execute stage; the ALU mux selects this block's ALU drive while busy is high.

---
 rtl/alu_mult_seq.sv | 203 ++++++++++++++++++++
 tb/tb_alu_mult_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_seq.sv
// ----------------------------------------------------------------------------
// alu_mult_seq
//   Multi-cycle multiply sequencer. Produces the low 32 bits of a 32x32
//   product, signed or unsigned, by shift-add iteration. It owns no adder of
//   its own: every sum and every negation goes through the shared ALU via
//   alu_op/alu_porta/alu_portb, and the ALU's combinational answer comes back
//   on alu_out within the same cycle. The execute-stage mux hands the ALU to
//   this block while busy is high.
//
// Parameters
//   EARLY_EXIT   1: leave the MUL loop once the remaining multiplier is zero.
//                0: always run 32 MUL iterations.
//
// Ports
//   CLK           in   system clock, rising edge
//   nRST          in   asynchronous active-low reset
//   start         in   request, sampled only in IDLE
//   is_signed     in   operands are two's complement (sampled with start)
//   a, b          in   multiplicand / multiplier (sampled with start)
//   busy          out  high in ABS_A, ABS_B, MUL, FIX
//   done          out  one-cycle pulse in DONE
//   result        out  low product, held until the next accepted start
//   alu_op        out  ALU operation (shared aluop_t encoding, 4 bits)
//   alu_porta     out  ALU port A
//   alu_portb     out  ALU port B
//   alu_out       in   ALU result
//   alu_zero, alu_negative, alu_overflow  in  ALU flags, not used
//   dbg_state     out  current FSM state:
//                      0 IDLE, 1 ABS_A, 2 ABS_B, 3 MUL, 4 FIX, 5 DONE
//
// Handshake: start is a level request looked at only while the FSM is in
// IDLE; at any other time it is ignored and the operands are not re-sampled.
// done is a single-cycle pulse; result is valid from that cycle onward and is
// held until the next accepted start completes.
// ----------------------------------------------------------------------------
module alu_mult_seq #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_porta,
  output logic [31:0] alu_portb,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  output logic [2:0]  dbg_state
);

  // Shared ALU operation codes (must match the execute-stage aluop_t).
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS_A = 3'd1,
    S_ABS_B = 3'd2,
    S_MUL   = 3'd3,
    S_FIX   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      r_state,  w_state_nxt;
  logic [31:0] r_mcand,  w_mcand_nxt;
  logic [31:0] r_mplier, w_mplier_nxt;
  logic [31:0] r_acc,    w_acc_nxt;
  logic [4:0]  r_count,  w_count_nxt;
  logic        r_neg,    w_neg_nxt;
  // Remembers whether b needs an ABS_B pass, so ABS_A can pick its successor
  // without looking at the (possibly changed) b input again.
  logic        r_neg_b,  w_neg_b_nxt;
  logic [31:0] r_result, w_result_nxt;

  logic [31:0] w_mplier_sh;
  logic        w_last;

  // Flags are deliberately ignored; control never depends on them.
  logic w_unused;
  assign w_unused = alu_zero ^ alu_negative ^ alu_overflow;

  assign w_mplier_sh = r_mplier >> 1;
  // Final MUL iteration: 32nd pass, or nothing left to add (early exit).
  assign w_last = (r_count == 5'd31) ||
                  ((EARLY_EXIT == 1'b1) && (w_mplier_sh == 32'd0));

  always_comb begin
    w_state_nxt  = r_state;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
    w_count_nxt  = r_count;
    w_neg_nxt    = r_neg;
    w_neg_b_nxt  = r_neg_b;
    w_result_nxt = r_result;
    alu_op       = ALU_ADD;
    alu_porta    = 32'd0;
    alu_portb    = 32'd0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mcand_nxt  = a;
          w_mplier_nxt = b;
          w_acc_nxt    = 32'd0;
          w_count_nxt  = 5'd0;
          w_neg_nxt    = is_signed & (a[31] ^ b[31]);
          w_neg_b_nxt  = is_signed & b[31];
          if (is_signed & a[31])      w_state_nxt = S_ABS_A;
          else if (is_signed & b[31]) w_state_nxt = S_ABS_B;
          else                        w_state_nxt = S_MUL;
        end
      end

      S_ABS_A: begin
        // 0 - x; 0x80000000 maps to itself, which is still right mod 2^32.
        alu_op      = ALU_SUB;
        alu_portb   = r_mcand;
        w_mcand_nxt = alu_out;
        w_state_nxt = r_neg_b ? S_ABS_B : S_MUL;
      end

      S_ABS_B: begin
        alu_op       = ALU_SUB;
        alu_portb    = r_mplier;
        w_mplier_nxt = alu_out;
        w_state_nxt  = S_MUL;
      end

      S_MUL: begin
        if (r_mplier[0]) begin
          alu_porta = r_acc;
          alu_portb = r_mcand;
          w_acc_nxt = alu_out;
        end
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = w_mplier_sh;
        w_count_nxt  = r_count + 5'd1;
        if (w_last) begin
          if (r_neg) begin
            w_state_nxt = S_FIX;
          end else begin
            // Capture the accumulator including this cycle's add.
            w_result_nxt = w_acc_nxt;
            w_state_nxt  = S_DONE;
          end
        end
      end

      S_FIX: begin
        alu_op       = ALU_SUB;
        alu_portb    = r_acc;
        w_acc_nxt    = alu_out;
        w_result_nxt = alu_out;
        w_state_nxt  = S_DONE;
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= S_IDLE;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_acc    <= 32'd0;
      r_count  <= 5'd0;
      r_neg    <= 1'b0;
      r_neg_b  <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_acc    <= w_acc_nxt;
      r_count  <= w_count_nxt;
      r_neg    <= w_neg_nxt;
      r_neg_b  <= w_neg_b_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign busy      = (r_state == S_ABS_A) || (r_state == S_ABS_B) ||
                     (r_state == S_MUL)   || (r_state == S_FIX);
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_mult_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_mult_seq
//   Two instances share clock, reset and operands: dut0 with EARLY_EXIT=0 and
//   dut1 with EARLY_EXIT=1, each with its own start and its own combinational
//   ALU. A transaction-level model predicts, per instance, the product and the
//   cycle count of every accepted request; a compare process checks busy,
//   done, result and the idle ALU drive against it on every falling edge.
//   Directed vectors add hand-computed result and latency checks.
// ----------------------------------------------------------------------------
module tb_alu_mult_seq;

  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]  start_v;
  logic        s_in;
  logic [31:0] a_in, b_in;
  logic [1:0]  busy_v, done_v;
  logic [31:0] res_w   [2];
  logic [3:0]  op_w    [2];
  logic [31:0] pa_w    [2];
  logic [31:0] pb_w    [2];
  logic [31:0] aout_w  [2];
  logic [1:0]  zero_v;
  logic [2:0]  dbg_w   [2];

  function automatic logic [31:0] alu_f(input logic [3:0] op,
                                        input logic [31:0] x, y);
    if (op == ALU_ADD) return x + y;
    if (op == ALU_SUB) return x - y;
    return 32'd0;
  endfunction

  assign aout_w[0] = alu_f(op_w[0], pa_w[0], pb_w[0]);
  assign aout_w[1] = alu_f(op_w[1], pa_w[1], pb_w[1]);
  assign zero_v[0] = (aout_w[0] == 32'd0);
  assign zero_v[1] = (aout_w[1] == 32'd0);

  alu_mult_seq #(.EARLY_EXIT(1'b0)) dut0 (
    .CLK(clk), .nRST(rst_n), .start(start_v[0]), .is_signed(s_in),
    .a(a_in), .b(b_in), .busy(busy_v[0]), .done(done_v[0]),
    .result(res_w[0]), .alu_op(op_w[0]), .alu_porta(pa_w[0]),
    .alu_portb(pb_w[0]), .alu_out(aout_w[0]), .alu_zero(zero_v[0]),
    .alu_negative(aout_w[0][31]), .alu_overflow(1'b0), .dbg_state(dbg_w[0])
  );

  alu_mult_seq #(.EARLY_EXIT(1'b1)) dut1 (
    .CLK(clk), .nRST(rst_n), .start(start_v[1]), .is_signed(s_in),
    .a(a_in), .b(b_in), .busy(busy_v[1]), .done(done_v[1]),
    .result(res_w[1]), .alu_op(op_w[1]), .alu_porta(pa_w[1]),
    .alu_portb(pb_w[1]), .alu_out(aout_w[1]), .alu_zero(zero_v[1]),
    .alu_negative(aout_w[1][31]), .alu_overflow(1'b0), .dbg_state(dbg_w[1])
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cycles from the accepting edge to the done cycle, counted from the rules:
  // one cycle per operand that needs negating, the multiply iterations, one
  // cycle to negate a negative product, and the done cycle itself.
  function automatic int calc_lat(input bit ee, input logic s,
                                  input logic [31:0] a, b);
    logic [31:0] mag_b;
    int mulc;
    mag_b = (s && b[31]) ? (32'd0 - b) : b;
    if (!ee) begin
      mulc = 32;
    end else begin
      mulc = 1;
      for (int i = 0; i < 32; i++) if (mag_b[i]) mulc = i + 1;
    end
    return int'(s && a[31]) + int'(s && b[31]) + mulc +
           int'(s && (a[31] ^ b[31])) + 1;
  endfunction

  // m_phase: 0 = idle, k = k-th cycle after the accepting edge.
  int          m_phase [2];
  int          m_lat   [2];
  logic [31:0] m_pend  [2];
  logic [31:0] m_res   [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i] <= 0;
        m_lat[i]   <= 0;
        m_pend[i]  <= 32'd0;
        m_res[i]   <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_phase[i] == 0) begin
          if (start_v[i]) begin
            m_phase[i] <= 1;
            m_lat[i]   <= calc_lat(i == 1, s_in, a_in, b_in);
            m_pend[i]  <= a_in * b_in;
          end
        end else if (m_phase[i] == m_lat[i]) begin
          m_phase[i] <= 0;
        end else begin
          m_phase[i] <= m_phase[i] + 1;
          if (m_phase[i] + 1 == m_lat[i]) m_res[i] <= m_pend[i];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic exp_busy, exp_done;
      exp_busy = (m_phase[i] >= 1) && (m_phase[i] < m_lat[i]);
      exp_done = (m_phase[i] != 0) && (m_phase[i] == m_lat[i]);
      chk($sformatf("busy%0d", i), {31'd0, busy_v[i]}, {31'd0, exp_busy});
      chk($sformatf("done%0d", i), {31'd0, done_v[i]}, {31'd0, exp_done});
      chk($sformatf("result%0d", i), res_w[i], m_res[i]);
      if (!exp_busy) begin
        chk($sformatf("idle_op%0d", i), {28'd0, op_w[i]}, {28'd0, ALU_ADD});
        chk($sformatf("idle_pa%0d", i), pa_w[i], 32'd0);
        chk($sformatf("idle_pb%0d", i), pb_w[i], 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one request to both instances and check hand-computed result and
  // latency. With poke set, a second request with other operands is pulsed
  // on cycle 3, while both instances are still working.
  task automatic run_op(input string name, input logic s,
                        input logic [31:0] a, b, exp_res,
                        input int exp_lat0, exp_lat1, input bit poke);
    int n, lat0, lat1, bc0, bc1;
    bit got0, got1;
    @(negedge clk);
    s_in = s; a_in = a; b_in = b; start_v = 2'b11;
    @(negedge clk);
    start_v = 2'b00;
    n = 1; got0 = 0; got1 = 0; lat0 = 0; lat1 = 0; bc0 = 0; bc1 = 0;
    while (!(got0 && got1) && n < 100) begin
      if (done_v[0] && !got0) begin lat0 = n; got0 = 1; end
      if (done_v[1] && !got1) begin lat1 = n; got1 = 1; end
      if (busy_v[0]) bc0++;
      if (busy_v[1]) bc1++;
      if (poke && n == 3) begin
        a_in = 32'd5; b_in = 32'd5; s_in = 1'b0; start_v = 2'b11;
      end else begin
        start_v = 2'b00;
      end
      @(negedge clk);
      n++;
    end
    chk({name, "_done0_seen"}, {31'd0, got0}, 32'd1);
    chk({name, "_done1_seen"}, {31'd0, got1}, 32'd1);
    chk({name, "_lat0"}, lat0, exp_lat0);
    chk({name, "_lat1"}, lat1, exp_lat1);
    chk({name, "_busy0_cycles"}, bc0, exp_lat0 - 1);
    chk({name, "_busy1_cycles"}, bc1, exp_lat1 - 1);
    chk({name, "_res0"}, res_w[0], exp_res);
    chk({name, "_res1"}, res_w[1], exp_res);
    repeat (3) @(negedge clk);
    chk({name, "_res0_held"}, res_w[0], exp_res);
    chk({name, "_res1_held"}, res_w[1], exp_res);
  endtask

  task automatic wait_done1(input string name);
    int n;
    n = 0;
    while (!done_v[1] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done1_seen"}, {31'd0, done_v[1]}, 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    start_v = 2'b00; s_in = 1'b0; a_in = 32'd0; b_in = 32'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_busy%0d", i), {31'd0, busy_v[i]}, 32'd0);
      chk($sformatf("rst_done%0d", i), {31'd0, done_v[i]}, 32'd0);
      chk($sformatf("rst_result%0d", i), res_w[i], 32'd0);
      chk($sformatf("rst_state%0d", i), {29'd0, dbg_w[i]}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    //      name       s     a             b             result        L0  L1
    run_op("u7x6",    1'b0, 32'd7,        32'd6,        32'd42,       33, 4,  0);
    run_op("sm3x5",   1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 35, 6,  0);
    run_op("sm4xm8",  1'b1, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'd32,       35, 7,  0);
    run_op("u9x0",    1'b0, 32'd9,        32'd0,        32'd0,        33, 2,  0);
    run_op("smin",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35, 4,  0);
    run_op("uwrap",   1'b0, 32'h00010000, 32'h00010000, 32'd0,        33, 18, 0);
    run_op("poke",    1'b0, 32'd3,        32'h00000100, 32'h00000300, 33, 10, 1);

    // start held high through DONE: ignored in DONE, taken the cycle after.
    @(negedge clk);
    s_in = 1'b0; a_in = 32'd6; b_in = 32'd7; start_v = 2'b10;
    @(negedge clk);
    wait_done1("hold");
    @(negedge clk);
    chk("hold_idle_after_done", {31'd0, busy_v[1]}, 32'd0);
    @(negedge clk);
    chk("hold_restart_busy", {31'd0, busy_v[1]}, 32'd1);
    start_v = 2'b00;
    wait_done1("hold2");
    chk("hold2_res1", res_w[1], 32'd42);
    repeat (2) @(negedge clk);

    // Reset in the middle of a multiply.
    @(negedge clk);
    s_in = 1'b0; a_in = 32'd1; b_in = 32'h0000FFFF; start_v = 2'b11;
    @(negedge clk);
    start_v = 2'b00;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy0", {31'd0, busy_v[0]}, 32'd1);
    chk("pre_rst_busy1", {31'd0, busy_v[1]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("async_busy%0d", i), {31'd0, busy_v[i]}, 32'd0);
      chk($sformatf("async_done%0d", i), {31'd0, done_v[i]}, 32'd0);
      chk($sformatf("async_result%0d", i), res_w[i], 32'd0);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_no_done0", {31'd0, done_v[0]}, 32'd0);
    chk("post_rst_no_done1", {31'd0, done_v[1]}, 32'd0);

    run_op("after_rst", 1'b1, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFEB, 35, 5, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
